// File: rtl/control_pkg.sv
// Shared encodings for the MIPS-subset decoder: opcodes, R-type funct codes,
// ALU operation enum, ALU B-operand select values and an instruction field splitter.
package control_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU operation codes
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_e;

  // ALU B operand select
  localparam logic ALU_SRC_REG   = 1'b0;
  localparam logic ALU_SRC_IMM16 = 1'b1;

  // Named instruction fields
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    logic [5:0] funct;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.op    = instr[31:26];
    f.rs    = instr[25:21];
    f.rt    = instr[20:16];
    f.rd    = instr[15:11];
    f.sh    = instr[10:6];
    f.funct = instr[5:0];
    return f;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct decoder: maps funct to ALU operation, flags shifts and reports
// whether the funct is supported. Extended functs (sub, or, nor, srl) are only
// decoded when CONTROL_EXT_OPS_EN is defined.
module alu_op_decode
  import control_pkg::*;
(
  input  logic [5:0] i_funct,
  output alu_op_e    o_alu_op,
  output logic       o_is_shift,
  output logic       o_valid
);

  // Funct lookup; unsupported functs fall back to ADD with valid=0
  always_comb begin
    o_alu_op   = OP_ADD;
    o_is_shift = 1'b0;
    o_valid    = 1'b0;
    case (i_funct)
      FUNCT_ADD: begin o_alu_op = OP_ADD; o_valid = 1'b1; end
      FUNCT_AND: begin o_alu_op = OP_AND; o_valid = 1'b1; end
      FUNCT_SLT: begin o_alu_op = OP_SLT; o_valid = 1'b1; end
      FUNCT_SLL: begin o_alu_op = OP_SLL; o_is_shift = 1'b1; o_valid = 1'b1; end
`ifdef CONTROL_EXT_OPS_EN
      FUNCT_SUB: begin o_alu_op = OP_SUB; o_valid = 1'b1; end
      FUNCT_OR:  begin o_alu_op = OP_OR;  o_valid = 1'b1; end
      FUNCT_NOR: begin o_alu_op = OP_NOR; o_valid = 1'b1; end
      FUNCT_SRL: begin o_alu_op = OP_SRL; o_is_shift = 1'b1; o_valid = 1'b1; end
`endif
      default: begin
        o_alu_op   = OP_ADD;
        o_is_shift = 1'b0;
        o_valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle MIPS-subset instruction decoder. All decode outputs are purely
// combinational; illegal_seen is a sticky register of any undecoded instruction
// since reset. Optional macro CONTROL_EXT_OPS_EN enables sub/or/nor/srl,
// andi/ori/lw, beq and j; without it those decode as illegal safe no-ops.
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  output logic        reg_write,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [4:0]  addr_a,
  output logic [4:0]  addr_b,
  output logic [4:0]  addr_in,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] addr26,
  output logic        is_jump,
  output logic        is_branch,
  output logic        illegal,
  output logic        illegal_seen
);

  instr_fields_t w_f;
  alu_op_e       w_funct_op;
  logic          w_is_shift;
  logic          w_funct_valid;
  logic          r_illegal_seen;

  assign w_f    = split_instr(instruction);
  assign imm16  = instruction[15:0];
  assign addr26 = instruction[25:0];
  assign illegal_seen = r_illegal_seen;

  alu_op_decode u_alu_op_decode (
    .i_funct    (w_f.funct),
    .o_alu_op   (w_funct_op),
    .o_is_shift (w_is_shift),
    .o_valid    (w_funct_valid)
  );

  // Opcode decode; defaults form the safe no-op used for anything undecoded
  always_comb begin
    reg_write = 1'b0;
    alu_src   = ALU_SRC_REG;
    alu_op    = OP_ADD;
    addr_a    = w_f.rs;
    addr_b    = w_f.rt;
    addr_in   = w_f.rd;
    shamt     = 5'd0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b1;
    case (w_f.op)
      OPC_RTYPE: begin
        if (w_funct_valid) begin
          reg_write = 1'b1;
          alu_op    = w_funct_op;
          illegal   = 1'b0;
          if (w_is_shift) begin
            // Shifts operate on rt, by the instruction's shift field
            addr_a = w_f.rt;
            shamt  = w_f.sh;
          end else begin
            addr_a = w_f.rs;
            shamt  = 5'd0;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_ADDI: begin
        addr_in   = w_f.rt;
        alu_src   = ALU_SRC_IMM16;
        alu_op    = OP_ADD;
        reg_write = 1'b1;
        illegal   = 1'b0;
      end
      OPC_SW: begin
        addr_in   = w_f.rt;
        alu_src   = ALU_SRC_IMM16;
        alu_op    = OP_ADD;
        reg_write = 1'b0;
        illegal   = 1'b0;
      end
      OPC_BNE: begin
        addr_in   = w_f.rt;
        alu_op    = OP_SUB;
        is_branch = 1'b1;
        illegal   = 1'b0;
      end
`ifdef CONTROL_EXT_OPS_EN
      OPC_ANDI: begin
        addr_in   = w_f.rt;
        alu_src   = ALU_SRC_IMM16;
        alu_op    = OP_AND;
        reg_write = 1'b1;
        illegal   = 1'b0;
      end
      OPC_ORI: begin
        addr_in   = w_f.rt;
        alu_src   = ALU_SRC_IMM16;
        alu_op    = OP_OR;
        reg_write = 1'b1;
        illegal   = 1'b0;
      end
      OPC_LW: begin
        addr_in   = w_f.rt;
        alu_src   = ALU_SRC_IMM16;
        alu_op    = OP_ADD;
        reg_write = 1'b1;
        illegal   = 1'b0;
      end
      OPC_BEQ: begin
        addr_in   = w_f.rt;
        alu_op    = OP_SUB;
        is_branch = 1'b1;
        illegal   = 1'b0;
      end
      OPC_J: begin
        is_jump = 1'b1;
        alu_op  = OP_ADD;
        illegal = 1'b0;
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Sticky record of any illegal instruction since reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal_seen <= 1'b0;
    end else begin
      r_illegal_seen <= r_illegal_seen | illegal;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: expected decode results are pushed to a
// scoreboard queue as each instruction is driven and popped/compared once the
// combinational outputs have settled; the sticky flag is checked around resets.
module tb_control_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction;
  logic        reg_write;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  addr_in;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        is_jump;
  logic        is_branch;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int errors = 0;

  // care bits: 0 rw, 1 src, 2 op, 3 a, 4 b, 5 in, 6 sh, 7 j, 8 br, 9 ill
  localparam logic [9:0] C_ALL = 10'h3FF;
  localparam logic [9:0] C_SW  = 10'h3BF;
  localparam logic [9:0] C_BR  = 10'h39F;
  localparam logic [9:0] C_JMP = 10'h385;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [9:0]  care;
    logic        rw;
    logic        src;
    logic [2:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  win;
    logic [4:0]  sh;
    logic        j;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  control_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instruction  (instruction),
    .reg_write    (reg_write),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .addr_in      (addr_in),
    .shamt        (shamt),
    .imm16        (imm16),
    .addr26       (addr26),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] instr, input logic [9:0] care,
                              input logic rw, input logic src, input logic [2:0] op,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] win,
                              input logic [4:0] sh, input logic j, input logic br, input logic ill);
    exp_t e;
    e.tag = tag; e.instr = instr; e.care = care;
    e.rw = rw; e.src = src; e.op = op; e.a = a; e.b = b; e.win = win; e.sh = sh;
    e.j = j; e.br = br; e.ill = ill;
    return e;
  endfunction

  // Pop the oldest expectation and compare every field it cares about
  task automatic check_out();
    exp_t e;
    logic [31:0] tmp;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      tmp = e.instr;
      chk({e.tag, ".imm16"},  {16'd0, imm16},  {16'd0, tmp[15:0]});
      chk({e.tag, ".addr26"}, {6'd0, addr26},  {6'd0, tmp[25:0]});
      if (e.care[0]) chk({e.tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
      if (e.care[1]) chk({e.tag, ".alu_src"},   {31'd0, alu_src},   {31'd0, e.src});
      if (e.care[2]) chk({e.tag, ".alu_op"},    {29'd0, alu_op},    {29'd0, e.op});
      if (e.care[3]) chk({e.tag, ".addr_a"},    {27'd0, addr_a},    {27'd0, e.a});
      if (e.care[4]) chk({e.tag, ".addr_b"},    {27'd0, addr_b},    {27'd0, e.b});
      if (e.care[5]) chk({e.tag, ".addr_in"},   {27'd0, addr_in},   {27'd0, e.win});
      if (e.care[6]) chk({e.tag, ".shamt"},     {27'd0, shamt},     {27'd0, e.sh});
      if (e.care[7]) chk({e.tag, ".is_jump"},   {31'd0, is_jump},   {31'd0, e.j});
      if (e.care[8]) chk({e.tag, ".is_branch"}, {31'd0, is_branch}, {31'd0, e.br});
      if (e.care[9]) chk({e.tag, ".illegal"},   {31'd0, illegal},   {31'd0, e.ill});
    end
  endtask

  // Drive an instruction at the falling edge, queue its expectation, compare after settling
  task automatic apply(input exp_t e);
    @(negedge clk);
    instruction = e.instr;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    reset_n     = 1'b0;
    instruction = 32'h00004020;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seen", {31'd0, illegal_seen}, 32'd0);

    // Illegal instruction while reset is held must not set the flag
    @(negedge clk);
    instruction = 32'hFC000000;
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_in_reset_seen", {31'd0, illegal_seen}, 32'd0);

    // Release reset with illegal op applied: flag sets on the next edge only
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(mk("op3f", 32'hFC000000, C_ALL, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
    #1;
    check_out();
    chk("pre_edge_seen", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_edge_seen", {31'd0, illegal_seen}, 32'd1);

    // Legal instructions afterwards never clear it
    @(negedge clk);
    instruction = 32'h00004020;
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_hold_seen", {31'd0, illegal_seen}, 32'd1);

    // Mid-cycle asynchronous reset clears immediately
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_clear_seen", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Legal-only stream keeps the flag clear
    apply(mk("addi", 32'h2010FEFE, C_ALL, 1'b1, 1'b1, 3'd0, 5'd0, 5'd16, 5'd16, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("sll",  32'h00108400, C_ALL, 1'b1, 1'b0, 3'd6, 5'd16, 5'd16, 5'd16, 5'd16, 1'b0, 1'b0, 1'b0));
    apply(mk("add",  32'h00004020, C_ALL, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("slt",  32'h0111482A, C_ALL, 1'b1, 1'b0, 3'd5, 5'd8, 5'd17, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("and",  32'h02114024, C_ALL, 1'b1, 1'b0, 3'd2, 5'd16, 5'd17, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("bne",  32'h1520FFFD, C_BR,  1'b0, 1'b0, 3'd1, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    apply(mk("sw",   32'hAD100000, C_SW,  1'b0, 1'b1, 3'd0, 5'd8, 5'd16, 5'd16, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("add_sh_nz", 32'h00004060, C_ALL, 1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("legal_stream_seen", {31'd0, illegal_seen}, 32'd0);

    // Undecoded funct is a safe no-op
    apply(mk("funct21", 32'h00004021, C_ALL, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1));

`ifdef CONTROL_EXT_OPS_EN
    apply(mk("sub", 32'h01094022, C_ALL, 1'b1, 1'b0, 3'd1, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk("j",   32'h08000010, C_JMP, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));
`else
    apply(mk("sub", 32'h01094022, C_ALL, 1'b0, 1'b0, 3'd0, 5'd8, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1));
    apply(mk("j",   32'h08000010, C_ALL, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
`endif

    @(posedge clk);
    #1;
    chk("final_seen", {31'd0, illegal_seen}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction decoder for the single-cycle MIPS-subset processor.
- Splits a 32-bit instruction into register addresses, shift amount, immediate and jump target fields.
- Produces ALU op/source select, register-write enable and jump/branch flags, all combinationally.
- Also holds one clocked sticky flag that records any illegal instruction seen since reset.

Parameters:
- None. All encodings come from the shared package.

Ports:
- clk  in  1  system clock; used only by the sticky flag.
- reset_n  in  1  asynchronous, active-low reset.
- instruction  in  32  current instruction word.
- reg_write  out  1  register file write enable.
- alu_src  out  1  ALU B operand select: ALU_SRC_REG=0, ALU_SRC_IMM16=1.
- alu_op  out  3  ALU operation code.
- addr_a  out  5  register file read port A address.
- addr_b  out  5  register file read port B address.
- addr_in  out  5  register file write address.
- shamt  out  5  shift amount.
- imm16  out  16  raw immediate, equal to instruction[15:0].
- addr26  out  26  jump target, equal to instruction[25:0].
- is_jump  out  1  unconditional jump.
- is_branch  out  1  conditional branch (beq/bne).
- illegal  out  1  combinational: current instruction is not decoded.
- illegal_seen  out  1  registered sticky copy of illegal.

Behaviour:
- Field names: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh=[10:6], funct=[5:0].
- All outputs except illegal_seen are purely combinational, with zero latency.
- imm16 and addr26 are always driven from their instruction bits, whatever the opcode.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, NOR=4, SLT=5, SLL=6, SRL=7.
- R-type (op=0x00) common settings:
  - addr_b=rt, addr_in=rd, reg_write=1, alu_src=REG, is_jump=0, is_branch=0.
  - addr_a=rs and shamt=0, except for shifts.
- R-type funct mapping:
  - 0x20→ADD, 0x22→SUB, 0x24→AND, 0x25→OR, 0x27→NOR, 0x2A→SLT.
  - 0x00 SLL and 0x02 SRL are shifts: addr_a=rt (the shifted source) and shamt=sh.
- addi (0x08), andi (0x0C), ori (0x0D), lw (0x23):
  - addr_a=rs, addr_b=rt, addr_in=rt, alu_src=IMM16, reg_write=1, shamt=0.
  - alu_op: addi/lw → ADD; andi → AND; ori → OR.
  - Sign versus zero extension of imm16 is the datapath's job.
- sw (0x2B): addr_a=rs, addr_b=rt, addr_in=rt, alu_src=IMM16, alu_op=ADD, reg_write=0.
- beq (0x04) / bne (0x05): addr_a=rs, addr_b=rt, alu_src=REG, alu_op=SUB, is_branch=1, reg_write=0.
- j (0x02): is_jump=1, reg_write=0, alu_op=ADD.
- Any other op or funct:
  - illegal=1, reg_write=0, is_jump=0, is_branch=0, alu_op=ADD, alu_src=REG, shamt=0.
  - addr_a=rs, addr_b=rt, addr_in=rd.
  - This safe no-op guarantees no architectural side effect.
- illegal_seen:
  - Asynchronously cleared to 0 while reset_n=0.
  - On each rising clk edge with reset_n=1, it becomes illegal_seen | illegal.
  - Once set it stays at 1 until reset; it is never cleared by a later legal instruction.
  - If reset_n deasserts on the same edge as an illegal instruction, the set takes effect on the next edge.
- Combinational outputs do not depend on reset_n.

Optional Feature:
- Macro: CONTROL_EXT_OPS_EN.
- When defined, the full set above is decoded.
- When undefined, only add, and, slt, sll, addi, sw and bne are decoded.
- Without the macro, sub, or, nor, srl, andi, ori, lw, beq and j are treated as illegal (safe no-op with illegal=1).

Decomposition:
- Package control_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_ADDI, …) and funct constants;
  - the 3-bit ALU op enum (OP_ADD … OP_SRL);
  - ALU_SRC_REG and ALU_SRC_IMM16.
- Sub-module alu_op_decode maps funct to {alu_op, is_shift, valid}.
- control_unit holds the opcode decode plus the sticky register.

Test Plan:
- addi $s0,$zero,0xFEFE (0x2010FEFE) → addr_a=0, addr_in=16, imm16=0xFEFE, alu_op=ADD, alu_src=IMM16, reg_write=1, shamt=0, is_jump=0, is_branch=0.
- sll $s0,$s0,16 (0x00108400) → addr_a=16, addr_in=16, shamt=16, alu_op=SLL, reg_write=1, is_jump=0, is_branch=0.
- add $t0,$zero,$zero (0x00004020) → addr_a=0, addr_b=0, addr_in=8, shamt=0, alu_op=ADD, is_jump=0, is_branch=0. Then slt $t1,$t0,$s1 (0x0111482A) → addr_a=8, addr_b=17, addr_in=9, alu_op=SLT.
- and $t0,$s0,$s1 (0x02114024) → addr_a=16, addr_b=17, addr_in=8, alu_op=AND.
- bne $t1,$zero,-3 (0x1520FFFD) → addr_a=9, addr_b=0, imm16=0xFFFD, is_branch=1, reg_write=0, alu_op=SUB. sw $s0,0($t0) (0xAD100000) → addr_a=8, addr_b=16, imm16=0, reg_write=0.
- Sticky flag sequence:
  - Hold reset_n=0 → illegal_seen=0.
  - Release reset_n, apply op=0x3F (0xFC000000) → illegal=1, reg_write=0; after the next clk edge illegal_seen=1.
  - Apply legal add for further clocks → illegal_seen stays 1.
  - Assert reset_n=0 mid-cycle → illegal_seen=0 immediately.
